// File: rtl/param_ram_arbiter.sv
// Two-requester round-robin front end for one param_ram instance.
// After reset, and again on init_req, a sweep writes zero to every RAM word.
module param_ram_arbiter #(
  parameter int WIDTH_DATA = 16,
  parameter int NUMWORDS   = 256,
  localparam int AW        = $clog2(NUMWORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    init_busy,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*AW-1:0]         req_addr,
  input  logic [2*WIDTH_DATA-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [WIDTH_DATA-1:0]   rsp_data,
  output logic                    ram_wr_en,
  output logic [AW-1:0]           ram_wr_addr,
  output logic [WIDTH_DATA-1:0]   ram_wr_data,
  output logic                    ram_rd_en,
  output logic [AW-1:0]           ram_rd_addr,
  input  logic [WIDTH_DATA-1:0]   ram_rd_data
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The counter is one bit wider than the address so the last sweep word never aliases 0.
  localparam logic [AW:0] LAST_WORD = (AW+1)'(NUMWORDS - 1);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [AW:0]             init_cnt_r;
  logic [AW:0]             init_cnt_nxt_s;
  logic                    rr_last_r;
  logic [1:0]              rsp_valid_r;
  logic [1:0]              grant_s;
  logic                    grant_idx_s;
  logic                    sel_we_s;
  logic [AW-1:0]           sel_addr_s;
  logic [WIDTH_DATA-1:0]   sel_wdata_s;

  // State register and sweep counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {(AW+1){1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
    end
  end

  // Next-state and sweep counter advance
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == LAST_WORD) begin
          state_nxt_s    = ST_RUN;
          init_cnt_nxt_s = {(AW+1){1'b0}};
        end else begin
          init_cnt_nxt_s = init_cnt_r + {{AW{1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_nxt_s    = ST_INIT;
          init_cnt_nxt_s = {(AW+1){1'b0}};
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_cnt_nxt_s = {(AW+1){1'b0}};
      end
    endcase
  end

  // Round-robin grant: with both valid, the requester that did not win last goes
  always_comb begin
    grant_s     = 2'b00;
    grant_idx_s = 1'b0;
    if (rst_n && (state_r == ST_RUN) && !init_req) begin
      case (req_valid)
        2'b01: begin
          grant_s     = 2'b01;
          grant_idx_s = 1'b0;
        end
        2'b10: begin
          grant_s     = 2'b10;
          grant_idx_s = 1'b1;
        end
        2'b11: begin
          grant_idx_s = ~rr_last_r;
          grant_s     = rr_last_r ? 2'b01 : 2'b10;
        end
        default: begin
          grant_s     = 2'b00;
          grant_idx_s = 1'b0;
        end
      endcase
    end else begin
      grant_s     = 2'b00;
      grant_idx_s = 1'b0;
    end
  end

  // Operand selection for the granted requester
  always_comb begin
    if (grant_idx_s) begin
      sel_we_s    = req_we[1];
      sel_addr_s  = req_addr[2*AW-1:AW];
      sel_wdata_s = req_wdata[2*WIDTH_DATA-1:WIDTH_DATA];
    end else begin
      sel_we_s    = req_we[0];
      sel_addr_s  = req_addr[AW-1:0];
      sel_wdata_s = req_wdata[WIDTH_DATA-1:0];
    end
  end

  // Output decode: sweep writes in INIT, granted operation in RUN, all quiet in reset
  always_comb begin
    init_busy   = 1'b1;
    ram_wr_en   = 1'b0;
    ram_wr_addr = {AW{1'b0}};
    ram_wr_data = {WIDTH_DATA{1'b0}};
    ram_rd_en   = 1'b0;
    ram_rd_addr = {AW{1'b0}};
    if (!rst_n) begin
      init_busy = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_busy   = 1'b1;
          ram_wr_en   = 1'b1;
          ram_wr_addr = init_cnt_r[AW-1:0];
          ram_wr_data = {WIDTH_DATA{1'b0}};
        end
        ST_RUN: begin
          init_busy = 1'b0;
          if ((grant_s != 2'b00) && sel_we_s) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = sel_addr_s;
            ram_wr_data = sel_wdata_s;
          end else if (grant_s != 2'b00) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = sel_addr_s;
          end else begin
            ram_wr_en = 1'b0;
            ram_rd_en = 1'b0;
          end
        end
        default: begin
          init_busy = 1'b1;
        end
      endcase
    end
  end

  // Round-robin history and read-response tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_r   <= 1'b1;
      rsp_valid_r <= 2'b00;
    end else begin
      if (grant_s != 2'b00) begin
        rr_last_r <= grant_idx_s;
      end
      rsp_valid_r <= ((grant_s != 2'b00) && !sel_we_s) ? grant_s : 2'b00;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = ram_rd_data;

endmodule
